// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store unit: op codes, error codes, op-class helpers.
package mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd8,
        SH       = 4'd9,
        SW       = 4'd10
    } mem_op_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } lsu_err_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_lane.sv
// Combinational lane logic: load extract/extend and store lane merge into an existing word.
module lsu_lane
    import mem_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    assign shamt   = {lane, 3'b000};
    assign shifted = rdata >> shamt;

    always_comb begin
        ld_data = rdata;
        case (op)
            LB:      ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     ld_data = {24'd0, shifted[7:0]};
            LH:      ld_data = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     ld_data = {16'd0, shifted[15:0]};
            default: ld_data = rdata;
        endcase
    end

    // SW uses an all-ones mask so the merge degenerates to wdata.
    always_comb begin
        mask = 32'hFFFF_FFFF;
        case (op)
            SB:      mask = 32'h0000_00FF << shamt;
            SH:      mask = 32'h0000_FFFF << shamt;
            default: mask = 32'hFFFF_FFFF;
        endcase
    end

    assign st_word = (rdata & ~mask) | ((wdata << shamt) & mask);

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: loads in 1 cycle, SB/SH via a stalled read-modify-write, registered MEM/WB.
// Define LSU_TRACE_EN to print one trace line per memory access or fault.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int DMEM_AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_regwrite,
    output logic        stall,
    output logic        dmem_memread,
    output logic        dmem_memwrite,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wd,
    input  logic [31:0] dmem_rd,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic [31:0] wb_data,
    output logic [1:0]  err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RMW  = 1'b1;

    logic [0:0]  state;
    logic [29:0] rmw_waddr;
    logic [1:0]  rmw_lane;
    logic [31:0] rmw_word;
    logic [31:0] rmw_wdata;
    logic [3:0]  rmw_op;

    logic        idle, in_rmw;
    logic        op_load, op_store, op_sub_store;
    logic        misalign, out_of_range, fault, acc_ok;
    lsu_err_t    fault_code;
    logic [3:0]  lane_op;
    logic [1:0]  lane_sel;
    logic [31:0] lane_rdata, lane_wdata, ld_data, st_word;

    assign idle   = (state == ST_IDLE);
    assign in_rmw = (state == ST_RMW);

    assign op_load      = is_load(in_op);
    assign op_store     = is_store(in_op);
    assign op_sub_store = (in_op == SB) || (in_op == SH);

    // Misalignment takes priority over the range check.
    assign misalign = (((in_op == LH) || (in_op == LHU) || (in_op == SH)) && in_addr[0])
                   || (((in_op == LW) || (in_op == SW)) && (in_addr[1:0] != 2'b00));
    assign out_of_range = |in_addr[31:DMEM_AW+2];
    assign fault      = in_valid && (op_load || op_store) && (misalign || out_of_range);
    assign fault_code = misalign ? ERR_MISALIGN : ERR_RANGE;
    assign acc_ok     = idle && in_valid && (op_load || op_store) && !fault;

    assign lane_op    = in_rmw ? rmw_op    : in_op;
    assign lane_sel   = in_rmw ? rmw_lane  : in_addr[1:0];
    assign lane_rdata = in_rmw ? rmw_word  : dmem_rd;
    assign lane_wdata = in_rmw ? rmw_wdata : in_wdata;

    lsu_lane u_lane (
        .op      (lane_op),
        .lane    (lane_sel),
        .rdata   (lane_rdata),
        .wdata   (lane_wdata),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    assign dmem_memread  = acc_ok && (op_load || op_sub_store);
    assign dmem_memwrite = !reset && ((acc_ok && (in_op == SW)) || in_rmw);
    assign dmem_addr     = in_rmw ? {rmw_waddr, 2'b00} : {in_addr[31:2], 2'b00};
    assign dmem_wd       = st_word;
    assign stall         = !reset && acc_ok && op_sub_store;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'd0;
            err         <= ERR_NONE;
        end else if (in_rmw) begin
            state       <= ST_IDLE;
            wb_valid    <= 1'b1;
            wb_regwrite <= 1'b0;
            wb_data     <= st_word;
            err         <= ERR_NONE;
        end else begin
            wb_rd <= in_rd;
            err   <= fault ? fault_code : ERR_NONE;
            if (!in_valid) begin
                wb_valid    <= 1'b0;
                wb_regwrite <= 1'b0;
            end else if (fault) begin
                wb_valid    <= 1'b1;
                wb_regwrite <= 1'b0;
            end else if (op_load) begin
                wb_valid    <= 1'b1;
                wb_regwrite <= in_regwrite;
                wb_data     <= ld_data;
            end else if (op_sub_store) begin
                wb_valid    <= 1'b0;
                wb_regwrite <= 1'b0;
                state       <= ST_RMW;
            end else if (op_store) begin
                wb_valid    <= 1'b1;
                wb_regwrite <= 1'b0;
                wb_data     <= st_word;
            end else begin
                wb_valid    <= 1'b1;
                wb_regwrite <= in_regwrite;
                wb_data     <= in_addr;
            end
        end
    end

    // Datapath latch for the write half of a read-modify-write.
    always_ff @(posedge clk) begin
        if (idle && acc_ok && op_sub_store) begin
            rmw_waddr <= in_addr[31:2];
            rmw_lane  <= in_addr[1:0];
            rmw_word  <= dmem_rd;
            rmw_wdata <= in_wdata;
            rmw_op    <= in_op;
        end
    end

`ifdef LSU_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (in_rmw)
                $display("[LSU][%0t] OP=%0h addr=%h data=%h", $time, rmw_op, dmem_addr, dmem_wd);
            else if (fault)
                $display("[LSU][%0t] OP=%0h addr=%h data=err%0d", $time, in_op, in_addr, fault_code);
            else if (acc_ok && op_load)
                $display("[LSU][%0t] OP=%0h addr=%h data=%h", $time, in_op, in_addr, ld_data);
            else if (acc_ok && (in_op == SW))
                $display("[LSU][%0t] OP=%0h addr=%h data=%h", $time, in_op, in_addr, dmem_wd);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a behavioural word-addressed data memory.
module tb_mem_stage_lsu;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        stall, dmem_memread, dmem_memwrite;
    logic [31:0] dmem_addr, dmem_wd, dmem_rd;
    logic        wb_valid, wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  err;

    logic [31:0] mem [0:255];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_idx;
    logic [31:0] pl_dat;

    int checks = 0;
    int errors = 0;
    int stall_cnt;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DMEM_AW(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_op         (in_op),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_rd         (in_rd),
        .in_regwrite   (in_regwrite),
        .stall         (stall),
        .dmem_memread  (dmem_memread),
        .dmem_memwrite (dmem_memwrite),
        .dmem_addr     (dmem_addr),
        .dmem_wd       (dmem_wd),
        .dmem_rd       (dmem_rd),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_regwrite   (wb_regwrite),
        .wb_data       (wb_data),
        .err           (err)
    );

    assign dmem_rd = mem[dmem_addr[9:2]];

    always @(posedge clk) begin
        if (pl_we)
            mem[pl_idx] <= pl_dat;
        else if (dmem_memwrite)
            mem[dmem_addr[9:2]] <= dmem_wd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx; pl_dat = dat;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd; in_rd = rd; in_regwrite = rw;
        #1;
    endtask

    task automatic hold_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_addr = 32'd0;
        in_wdata = 32'd0; in_rd = 5'd0; in_regwrite = 1'b0;
        preload(8'd4, 32'h8899AABB);
        preload(8'd8, 32'h0000_0000);
        step();
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Load extraction from word 4 = 0x8899AABB, lane 2
        issue(LB, 32'h12, 32'd0, 5'd3, 1'b1);
        chk("lb_memread", {31'd0, dmem_memread}, 32'd1);
        chk("lb_stall", {31'd0, stall}, 32'd0);
        chk("lb_addr", dmem_addr, 32'h10);
        step();
        chk("lb_data", wb_data, 32'hFFFFFF99);
        chk("lb_valid", {31'd0, wb_valid}, 32'd1);
        chk("lb_regwrite", {31'd0, wb_regwrite}, 32'd1);
        chk("lb_rd", {27'd0, wb_rd}, 32'd3);
        issue(LBU, 32'h12, 32'd0, 5'd3, 1'b1);
        chk("lbu_stall", {31'd0, stall}, 32'd0);
        step();
        chk("lbu_data", wb_data, 32'h00000099);
        issue(LH, 32'h12, 32'd0, 5'd3, 1'b1);
        step();
        chk("lh_data", wb_data, 32'hFFFF8899);
        issue(LHU, 32'h10, 32'd0, 5'd3, 1'b1);
        step();
        chk("lhu_data", wb_data, 32'h0000AABB);

        // SB into lane 1 of word 4
        issue(SB, 32'h11, 32'h000000CC, 5'd0, 1'b0);
        chk("sb_stall", {31'd0, stall}, 32'd1);
        chk("sb_memread", {31'd0, dmem_memread}, 32'd1);
        chk("sb_nowrite", {31'd0, dmem_memwrite}, 32'd0);
        step();
        chk("sb_bubble", {31'd0, wb_valid}, 32'd0);
        hold_cycle();
        chk("sb_rmw_stall", {31'd0, stall}, 32'd0);
        chk("sb_rmw_write", {31'd0, dmem_memwrite}, 32'd1);
        chk("sb_rmw_addr", dmem_addr, 32'h10);
        chk("sb_rmw_wd", dmem_wd, 32'h8899CCBB);
        step();
        chk("sb_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("sb_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        issue(LW, 32'h10, 32'd0, 5'd7, 1'b1);
        chk("lw_after_sb_memread", {31'd0, dmem_memread}, 32'd1);
        step();
        chk("lw_after_sb", wb_data, 32'h8899CCBB);

        // SH then SB back-to-back on zeroed word 8
        stall_cnt = 0;
        issue(SH, 32'h22, 32'h00001234, 5'd0, 1'b0);
        if (stall) stall_cnt++;
        step();
        hold_cycle();
        if (stall) stall_cnt++;
        chk("sh_rmw_wd", dmem_wd, 32'h12340000);
        step();
        issue(SB, 32'h20, 32'h00000056, 5'd0, 1'b0);
        if (stall) stall_cnt++;
        step();
        hold_cycle();
        if (stall) stall_cnt++;
        chk("sb2_rmw_wd", dmem_wd, 32'h12340056);
        step();
        chk("b2b_stalls", stall_cnt, 32'd2);
        issue(LW, 32'h20, 32'd0, 5'd7, 1'b1);
        step();
        chk("b2b_final", wb_data, 32'h12340056);

        // Misaligned LW
        issue(LW, 32'h13, 32'd0, 5'd7, 1'b1);
        chk("mis_memread", {31'd0, dmem_memread}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        step();
        chk("mis_err", {30'd0, err}, 32'd1);
        chk("mis_valid", {31'd0, wb_valid}, 32'd1);
        chk("mis_regwrite", {31'd0, wb_regwrite}, 32'd0);
        @(negedge clk); in_valid = 1'b0;
        step();
        chk("mis_err_pulse", {30'd0, err}, 32'd0);
        chk("idle_valid", {31'd0, wb_valid}, 32'd0);

        // Out-of-range SH
        issue(SH, 32'h400, 32'h0000BEEF, 5'd0, 1'b0);
        chk("oor_memwrite", {31'd0, dmem_memwrite}, 32'd0);
        chk("oor_memread", {31'd0, dmem_memread}, 32'd0);
        chk("oor_stall", {31'd0, stall}, 32'd0);
        step();
        chk("oor_err", {30'd0, err}, 32'd2);
        chk("oor_regwrite", {31'd0, wb_regwrite}, 32'd0);
        chk("oor_memwrite_after", {31'd0, dmem_memwrite}, 32'd0);

        // Misaligned and out of range together reports misalign
        issue(LH, 32'h401, 32'd0, 5'd7, 1'b1);
        step();
        chk("mis_prio_err", {30'd0, err}, 32'd1);

        // MEM_NONE pass-through
        issue(MEM_NONE, 32'hDEADBEEF, 32'd0, 5'd5, 1'b1);
        chk("none_memread", {31'd0, dmem_memread}, 32'd0);
        chk("none_memwrite", {31'd0, dmem_memwrite}, 32'd0);
        step();
        chk("none_data", wb_data, 32'hDEADBEEF);
        chk("none_rd", {27'd0, wb_rd}, 32'd5);
        chk("none_regwrite", {31'd0, wb_regwrite}, 32'd1);
        chk("none_err", {30'd0, err}, 32'd0);

        // Undefined op code acts as MEM_NONE (no alignment fault)
        issue(4'd7, 32'h13, 32'd0, 5'd9, 1'b1);
        chk("undef_memread", {31'd0, dmem_memread}, 32'd0);
        step();
        chk("undef_data", wb_data, 32'h13);
        chk("undef_err", {30'd0, err}, 32'd0);

        // SW full word
        issue(SW, 32'h30, 32'hCAFEF00D, 5'd0, 1'b0);
        chk("sw_memwrite", {31'd0, dmem_memwrite}, 32'd1);
        chk("sw_wd", dmem_wd, 32'hCAFEF00D);
        chk("sw_stall", {31'd0, stall}, 32'd0);
        step();
        chk("sw_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        chk("sw_mem", mem[12], 32'hCAFEF00D);

        // Reset during the RMW cycle abandons the write
        issue(SB, 32'h10, 32'h00000077, 5'd0, 1'b0);
        step();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstrmw_memwrite", {31'd0, dmem_memwrite}, 32'd0);
        chk("rstrmw_stall", {31'd0, stall}, 32'd0);
        step();
        chk("rstrmw_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rstrmw_wb_data", wb_data, 32'd0);
        chk("rstrmw_err", {30'd0, err}, 32'd0);
        chk("rstrmw_mem", mem[4], 32'h8899CCBB);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        issue(LW, 32'h10, 32'd0, 5'd2, 1'b1);
        chk("rstrmw_idle_memread", {31'd0, dmem_memread}, 32'd1);
        step();
        chk("rstrmw_word", wb_data, 32'h8899CCBB);

        @(negedge clk);
        in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the pipeline's MEM stage, directly upstream of the word-addressed data memory. Combinational read, synchronous write, 32-bit words.
- Takes EX/MEM requests and drives the data memory's memread/memwrite/addr/wd.
- Extracts and sign/zero-extends load data.
- Performs read-modify-write for byte/halfword stores, stalling the pipeline one cycle.
- Registers the MEM/WB result.

Parameters:
- DMEM_AW, 8, word-index bits of the data memory (256 words); byte addresses with any bit set above DMEM_AW+1 are out of range.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM slot holds a live instruction
- in_op  in  4  mem_op_t operation
- in_addr  in  32  byte address; ALU result for MEM_NONE
- in_wdata  in  32  store data, lane 0 aligned (rs2 value)
- in_rd  in  5  destination register
- in_regwrite  in  1  instruction writes rd
- stall  out  1  hold IF..EX/MEM this cycle
- dmem_memread  out  1  to data memory
- dmem_memwrite  out  1  to data memory
- dmem_addr  out  32  word-aligned address {in_addr[31:2],2'b00}
- dmem_wd  out  32  write word
- dmem_rd  in  32  read word (combinational)
- wb_valid  out  1  MEM/WB slot live
- wb_rd  out  5  MEM/WB destination
- wb_regwrite  out  1  MEM/WB write enable
- wb_data  out  32  load result or ALU result
- err  out  2  registered: 0 none, 1 misaligned, 2 out of range; 1-cycle pulse

Behaviour:
- Reset: state=IDLE; wb_valid, wb_regwrite, wb_rd, wb_data, err all 0.
- While reset is high, dmem_memwrite=0 and stall=0 combinationally. A reset during RMW abandons the write.
- Byte lane = in_addr[1:0].
- Misaligned:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - Misalignment is checked before range.
- Faulting op (misaligned or out of range):
  - memread=memwrite=0, no stall.
  - Next edge: wb_valid=1, wb_regwrite=0, err=code.
- State IDLE, in_valid=1:
  - MEM_NONE: no dmem access. Next edge: wb_data=in_addr, wb_regwrite=in_regwrite.
  - LW/LH/LHU/LB/LBU: memread=1. Next edge: wb_data=extracted lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); wb_regwrite=in_regwrite. Latency 1 cycle to WB.
  - SW: memwrite=1, wd=in_wdata. Next edge: wb_valid=1, wb_regwrite=0.
  - SB/SH: memread=1, stall=1.
    - Next edge: capture dmem_rd into rmw_word; latch addr, lane, wdata and op; go to RMW.
    - WB gets a bubble: wb_valid=0, wb_regwrite=0.
- State RMW:
  - in_* ignored; upstream still holds the same instruction.
  - memwrite=1, addr=latched word address, wd=rmw_word with the byte/halfword lane replaced by wdata[7:0] or [15:0]; stall=0.
  - Next edge: back to IDLE; wb_valid=1, wb_regwrite=0.
- in_valid=0 in IDLE: no access. Next edge: wb_valid=0, wb_regwrite=0.
- rd=x0: wb_regwrite passes through unchanged; the register file discards x0 writes.
- Back-to-back SB/SB: the second is seen in IDLE after RMW and does a fresh read, so it observes the first write.
- A load immediately after SB/SH reads the post-write word.
- Undefined op codes behave as MEM_NONE.

Optional Feature:
- Macro: LSU_TRACE_EN.
- Defined: on each clock edge with an access, $display one line:
  - "[LSU][time] OP addr=.. data=.."
  - Covers loads (extracted value), stores (final word written) and faults (err code).
- Undefined: no display statements; logic is identical.

Decomposition:
- Package mem_pkg:
  - mem_op_t enum (4 bits): MEM_NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=8, SH=9, SW=10.
  - lsu_err_t enum (2 bits): ERR_NONE=0, ERR_MISALIGN=1, ERR_RANGE=2.
  - Helper functions is_load(op) and is_store(op).
- Sub-module lsu_lane: purely combinational load extract/extend and store lane merge. Shared by the load path and the RMW path.

Test Plan:
- Preload word 4 = 0x8899AABB; LB addr 0x12 → wb_data=0xFFFFFF99; LBU addr 0x12 → 0x00000099; LH addr 0x12 → 0xFFFF8899; one cycle each, no stall.
- SB addr 0x11, wdata=0x000000CC on word 4 = 0x8899AABB:
  - stall=1 for exactly one cycle, then memwrite with wd=0x8899CCBB.
  - Following LW 0x10 → 0x8899CCBB.
- SH addr 0x22 (wdata 0x1234) then SB addr 0x20 (wdata 0x56) back-to-back on a zero word → final word 0x12340056; two stall cycles total.
- LW addr 0x13 → no memread, err=1 for one cycle, wb_regwrite=0. SH addr 0x400 (DMEM_AW=8) → err=2, memwrite never asserted.
- Assert reset during the RMW cycle of SB 0x10 → memwrite=0 that cycle, memory unchanged, all wb outputs 0, state IDLE.
- MEM_NONE with in_addr=0xDEADBEEF, in_rd=5, regwrite=1 → wb_data=0xDEADBEEF, wb_rd=5, no dmem access.
